// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared ALU opcodes and sequencer state encoding
package alu_ctrl_pkg;

  localparam logic [3:0] OP_OR        = 4'd0;
  localparam logic [3:0] OP_AND       = 4'd1;
  localparam logic [3:0] OP_NOT       = 4'd2;
  localparam logic [3:0] OP_MAX_LEGAL = 4'd2;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_IDLE   = 3'd0;
  localparam seq_state_t ST_LOAD_Y = 3'd1;
  localparam seq_state_t ST_EXEC   = 3'd2;
  localparam seq_state_t ST_WRITE  = 3'd3;
  localparam seq_state_t ST_FAULT  = 3'd4;

endpackage

// File: rtl/alu_strobe_decode.sv
// rtl/alu_strobe_decode.sv - Moore decode of sequencer state and latched command into datapath strobes
module alu_strobe_decode
  import alu_ctrl_pkg::*;
#(
  parameter int REG_W = 4,
  parameter int OP_W  = 4
) (
  input  seq_state_t       state,
  input  logic [OP_W-1:0]  op,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  output logic             cmd_ready,
  output logic [REG_W-1:0] reg_sel,
  output logic             reg_out,
  output logic             reg_in,
  output logic             y_in,
  output logic [OP_W-1:0]  alu_op,
  output logic             z_in,
  output logic             z_out,
  output logic             done,
  output logic             err
);

  always_comb begin
    cmd_ready = 1'b0;
    reg_sel   = '0;
    reg_out   = 1'b0;
    reg_in    = 1'b0;
    y_in      = 1'b0;
    alu_op    = '0;
    z_in      = 1'b0;
    z_out     = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      ST_IDLE: cmd_ready = 1'b1;
      ST_LOAD_Y: begin
        reg_sel = rs;
        reg_out = 1'b1;
        y_in    = 1'b1;
      end
      ST_EXEC: begin
        alu_op = op;
        z_in   = 1'b1;
        // NOT is unary: leave the bus undriven so rt is never read
        if (op != OP_W'(OP_NOT)) begin
          reg_sel = rt;
          reg_out = 1'b1;
        end
      end
      ST_WRITE: begin
        z_out   = 1'b1;
        reg_sel = rd;
        reg_in  = 1'b1;
        done    = 1'b1;
      end
      ST_FAULT: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - three-cycle Rd <= Rs op Rt sequencer for the shared-bus ALU datapath
module alu_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int REG_W = 4,
  parameter int OP_W  = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [REG_W-1:0] cmd_rd,
  input  logic [REG_W-1:0] cmd_rs,
  input  logic [REG_W-1:0] cmd_rt,
  output logic [REG_W-1:0] reg_sel,
  output logic             reg_out,
  output logic             reg_in,
  output logic             y_in,
  output logic [OP_W-1:0]  alu_op,
  output logic             z_in,
  output logic             z_out,
  output logic             done,
  output logic             err
);

  seq_state_t       state;
  logic [OP_W-1:0]  lat_op;
  logic [REG_W-1:0] lat_rd;
  logic [REG_W-1:0] lat_rs;
  logic [REG_W-1:0] lat_rt;

  // Outputs depend only on state, so the async clear reaches them without a clock edge
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state  <= ST_IDLE;
      lat_op <= '0;
      lat_rd <= '0;
      lat_rs <= '0;
      lat_rt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            lat_op <= cmd_op;
            lat_rd <= cmd_rd;
            lat_rs <= cmd_rs;
            lat_rt <= cmd_rt;
            state  <= (cmd_op <= OP_W'(OP_MAX_LEGAL)) ? ST_LOAD_Y : ST_FAULT;
          end
        end
        ST_LOAD_Y: state <= ST_EXEC;
        ST_EXEC:   state <= ST_WRITE;
        ST_WRITE:  state <= ST_IDLE;
        ST_FAULT:  state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  alu_strobe_decode #(
    .REG_W(REG_W),
    .OP_W (OP_W)
  ) u_decode (
    .state    (state),
    .op       (lat_op),
    .rd       (lat_rd),
    .rs       (lat_rs),
    .rt       (lat_rt),
    .cmd_ready(cmd_ready),
    .reg_sel  (reg_sel),
    .reg_out  (reg_out),
    .reg_in   (reg_in),
    .y_in     (y_in),
    .alu_op   (alu_op),
    .z_in     (z_in),
    .z_out    (z_out),
    .done     (done),
    .err      (err)
  );

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed-vector bench with a register-file/Y/Z/ALU datapath model
module tb_alu_sequencer;
  import alu_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        clear;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op, cmd_rd, cmd_rs, cmd_rt;
  logic [3:0]  reg_sel;
  logic        reg_out, reg_in, y_in, z_in, z_out, done, err;
  logic [3:0]  alu_op;

  alu_sequencer #(.REG_W(4), .OP_W(4)) dut (
    .clock(clock), .clear(clear),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
    .reg_sel(reg_sel), .reg_out(reg_out), .reg_in(reg_in), .y_in(y_in),
    .alu_op(alu_op), .z_in(z_in), .z_out(z_out), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  logic [31:0] regs [16];
  logic [31:0] y_reg, z_reg, bus, alu_res;
  logic        pl_we = 1'b0;
  logic [3:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  always_comb begin
    bus = 32'h0;
    if (reg_out) bus = regs[reg_sel];
    else if (z_out) bus = z_reg;
  end

  always_comb begin
    alu_res = 32'h0;
    case (alu_op)
      OP_OR:   alu_res = y_reg | bus;
      OP_AND:  alu_res = y_reg & bus;
      OP_NOT:  alu_res = ~y_reg;
      default: alu_res = 32'h0;
    endcase
  end

  always @(posedge clock) begin
    if (pl_we) regs[pl_idx] <= pl_data;
    else if (reg_in) regs[reg_sel] <= bus;
    if (y_in) y_reg <= bus;
    if (z_in) z_reg <= alu_res;
  end

  int bus_viol = 0;
  int err_cnt  = 0;
  always @(negedge clock) begin
    if (reg_out && z_out) bus_viol++;
    if (err) err_cnt++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    @(negedge clock);
    pl_we = 1'b1; pl_idx = idx; pl_data = val;
    @(negedge clock);
    pl_we = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [6:0] strobes();
    return {reg_out, reg_in, y_in, z_in, z_out, done, err};
  endfunction

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{4'd1, 4'd3,  4'd1,  4'd2,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F};
    vecs[1] = '{4'd0, 4'd4,  4'd6,  4'd7,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678};
    vecs[2] = '{4'd2, 4'd5,  4'd5,  4'd9,  32'h0000_FFFF, 32'hDEAD_BEEF, 32'hFFFF_0000};
    vecs[3] = '{4'd1, 4'd8,  4'd8,  4'd8,  32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'hA5A5_5A5A};
    vecs[4] = '{4'd0, 4'd10, 4'd11, 4'd10, 32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0};

    clear = 1'b1; cmd_valid = 1'b1;
    cmd_op = 4'd0; cmd_rd = 4'd7; cmd_rs = 4'd1; cmd_rt = 4'd2;

    // Reset held with a pending command: nothing may be accepted
    preload(4'd1, 32'hF0F0_00FF);
    preload(4'd2, 32'h0FF0_0F0F);
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_ready", cmd_ready, 1'b1);
      check("reset_strobes", strobes(), 7'b0);
      check("reset_sel_op", {reg_sel, alu_op}, 8'h0);
    end
    @(negedge clock);
    clear = 1'b0;
    step();
    check("post_reset_accept_ready", cmd_ready, 1'b0);
    check("post_reset_loady", {y_in, reg_out, reg_sel}, {1'b1, 1'b1, 4'd1});
    @(negedge clock);
    cmd_valid = 1'b0;
    step(); step(); step();
    check("post_reset_R7", regs[7], 32'hFFF0_0FFF);

    foreach (vecs[i]) begin
      preload(vecs[i].rs, vecs[i].a);
      preload(vecs[i].rt, vecs[i].b);
      @(negedge clock);
      cmd_valid = 1'b1;
      cmd_op = vecs[i].op; cmd_rd = vecs[i].rd; cmd_rs = vecs[i].rs; cmd_rt = vecs[i].rt;
      step();
      check($sformatf("v%0d_loady_strobes", i), strobes(), 7'b1010000);
      check($sformatf("v%0d_loady_sel", i), reg_sel, vecs[i].rs);
      check($sformatf("v%0d_loady_ready", i), cmd_ready, 1'b0);
      @(negedge clock);
      cmd_valid = 1'b0;
      cmd_op = 4'hF; cmd_rd = 4'hF; cmd_rs = 4'hF; cmd_rt = 4'hF;
      step();
      check($sformatf("v%0d_exec_op", i), alu_op, vecs[i].op);
      check($sformatf("v%0d_exec_zin", i), z_in, 1'b1);
      check($sformatf("v%0d_exec_regout", i), reg_out, (vecs[i].op != 4'd2));
      if (vecs[i].op != 4'd2) check($sformatf("v%0d_exec_sel", i), reg_sel, vecs[i].rt);
      step();
      check($sformatf("v%0d_write_strobes", i), strobes(), 7'b0100110);
      check($sformatf("v%0d_write_sel", i), reg_sel, vecs[i].rd);
      step();
      check($sformatf("v%0d_idle_ready", i), {cmd_ready, done}, 2'b10);
      check($sformatf("v%0d_result", i), regs[vecs[i].rd], vecs[i].exp);
      if (vecs[i].rt != vecs[i].rd)
        check($sformatf("v%0d_rt_untouched", i), regs[vecs[i].rt], vecs[i].b);
    end

    // Back-to-back with cmd_valid held: second command must see the updated R4
    preload(4'd1, 32'hF0F0_00FF);
    preload(4'd2, 32'h0FF0_0F0F);
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_rd = 4'd4; cmd_rs = 4'd1; cmd_rt = 4'd2;
    step();
    cmd_op = 4'd1; cmd_rd = 4'd6; cmd_rs = 4'd4; cmd_rt = 4'd1;
    check("b2b_k1_busy", cmd_ready, 1'b0);
    step();
    check("b2b_k2_busy", cmd_ready, 1'b0);
    step();
    check("b2b_k3_done", {cmd_ready, done}, 2'b01);
    step();
    check("b2b_k4_ready", cmd_ready, 1'b1);
    check("b2b_R4", regs[4], 32'hFFF0_0FFF);
    step();
    check("b2b_second_accept", {y_in, reg_sel}, {1'b1, 4'd4});
    @(negedge clock);
    cmd_valid = 1'b0;
    step(); step(); step();
    check("b2b_R6", regs[6], 32'hF0F0_00FF);

    // Unsupported opcode
    preload(4'd12, 32'h1111_1111);
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = 4'd7; cmd_rd = 4'd12; cmd_rs = 4'd1; cmd_rt = 4'd2;
    step();
    check("fault_strobes", strobes(), 7'b0000011);
    check("fault_ready", cmd_ready, 1'b0);
    @(negedge clock);
    cmd_valid = 1'b0;
    step();
    check("fault_recover", {cmd_ready, done, err}, 3'b100);
    step();
    check("fault_R12", regs[12], 32'h1111_1111);

    // Clear asserted between edges during EXEC
    preload(4'd13, 32'h5555_5555);
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_rd = 4'd13; cmd_rs = 4'd1; cmd_rt = 4'd2;
    step();
    @(negedge clock);
    cmd_valid = 1'b0;
    step();
    check("clr_exec_reached", z_in, 1'b1);
    #2;
    clear = 1'b1;
    #1;
    check("clr_comb_ready", cmd_ready, 1'b1);
    check("clr_comb_strobes", strobes(), 7'b0);
    step();
    check("clr_held_strobes", {cmd_ready, strobes()}, 8'b1000_0000);
    step();
    @(negedge clock);
    clear = 1'b0;
    step(); step();
    check("clr_R13", regs[13], 32'h5555_5555);
    check("clr_idle", {cmd_ready, done}, 2'b10);

    check("single_bus_violations", bus_viol, 0);
    check("err_pulse_count", err_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
